// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, line levels and receiver state encoding.
package uart_pkg;

    localparam int DATA_BITS       = 8;
    localparam int DEFAULT_CLK_DIV = 2500;

    // Line levels shared with the transmit side
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef logic [2:0] state_t;
    localparam state_t IDLE      = 3'd0;
    localparam state_t START     = 3'd1;
    localparam state_t DATA      = 3'd2;
    localparam state_t PARITY    = 3'd3;
    localparam state_t STOP      = 3'd4;
    localparam state_t WAIT_IDLE = 3'd5;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Receiver output bundle. parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_frame_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;

    modport master (output rx_data, rx_valid, frame_err, busy, parity_err);
    modport slave  (input  rx_data, rx_valid, frame_err, busy, parity_err);
`else
    modport master (output rx_data, rx_valid, frame_err, busy);
    modport slave  (input  rx_data, rx_valid, frame_err, busy);
`endif

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX line plus a falling-edge detector.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic line_rx,
    output logic rxs,
    output logic fall_pulse
);

    logic meta;
    logic sync;
    logic prev;

    // Reset to the idle level so leaving reset never looks like a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= LINE_IDLE;
            sync <= LINE_IDLE;
            prev <= LINE_IDLE;
        end else begin
            // NOTE: non-blocking assignments make this a true three-stage shift;
            // blocking ones would collapse the chain into a single flop.
            meta <= line_rx;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rxs        = sync;
    assign fall_pulse = prev & ~sync;

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver (8E1 with parity check when UART_RX_PARITY_EN is defined).
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            line_rx,
    uart_rx_frame_if.master rx
);

    localparam int          HALF_DIV = CLK_DIV / 2;
    localparam logic [12:0] CNT_LAST = 13'(CLK_DIV - 1);
    localparam logic [12:0] CNT_HALF = 13'(HALF_DIV - 1);

    logic                 rxs;
    logic                 fall_pulse;
    state_t               state;
    logic [12:0]          cnt;
    logic [2:0]           idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
    logic                 perr_q;
`endif

    uart_rx_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_rx    (line_rx),
        .rxs        (rxs),
        .fall_pulse (fall_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (fall_pulse) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        idx <= '0;
                        state <= (rxs == START_BIT) ? DATA : IDLE;
                    end else begin
                        cnt <= cnt + 13'd1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt        <= '0;
                        shreg[idx] <= rxs;
                        idx        <= idx + 3'd1;
                        if (idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 13'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        par_bit <= rxs;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 13'd1;
                    end
                end
`endif
                STOP: begin
                    // Leave at mid-stop so a start edge right after the stop bit is caught
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rxs == STOP_BIT) begin
                            state <= IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_bit != even_parity(shreg)) begin
                                perr_q <= 1'b1;
                            end else begin
                                data_q  <= shreg;
                                valid_q <= 1'b1;
                            end
`else
                            data_q  <= shreg;
                            valid_q <= 1'b1;
`endif
                        end else begin
                            ferr_q <= 1'b1;
                            state  <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 13'd1;
                    end
                end
                WAIT_IDLE: begin
                    if (rxs == LINE_IDLE) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx.rx_data   = data_q;
    assign rx.rx_valid  = valid_q;
    assign rx.frame_err = ferr_q;
    assign rx.busy      = (state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed frames plus randomized traffic against a frame-level model.
module tb_uart_rx_frame;
    import uart_pkg::*;

    localparam int CLK_DIV = 16;
    localparam int HALF    = CLK_DIV / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS   = 11;
    localparam int LAT_LIT = 170;
    localparam int GAP_LIT = 176;
`else
    localparam int NBITS   = 10;
    localparam int LAT_LIT = 154;
    localparam int GAP_LIT = 160;
`endif
    // Strobe appears at the last sample point (HALF + (NBITS-1) bit periods after the
    // detected edge), which itself trails the line edge by the two synchroniser flops.
    localparam int LAT = 2 + HALF + (NBITS - 1) * CLK_DIV;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic line_rx = 1'b1;
    logic perr;

    uart_rx_frame_if bus ();

    uart_rx_frame #(.CLK_DIV(CLK_DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_rx (line_rx),
        .rx      (bus)
    );

`ifdef UART_RX_PARITY_EN
    assign perr = bus.parity_err;
`else
    assign perr = 1'b0;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         kind;   // 1 = valid, 2 = frame error, 3 = parity error
        logic [7:0] data;
    } exp_t;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_data = 8'h00;
    int         last_valid_cyc = -1;
    int         n_ferr = 0;
    int         n_perr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level scoreboard, evaluated every cycle away from the active edge
    always @(negedge clk) begin
        int k;
        if (!rst_n) begin
            q.delete();
            exp_data = 8'h00;
        end else begin
            k = bus.rx_valid ? 1 : bus.frame_err ? 2 : perr ? 3 : 0;
            check("valid_ferr_exclusive", {31'd0, bus.rx_valid & bus.frame_err}, 0);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                check("missing_strobe", 0, q[0].kind);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                check("strobe_kind", k, q[0].kind);
                if (q[0].kind == 1) exp_data = q[0].data;
                if (k == 1) last_valid_cyc = cyc;
                void'(q.pop_front());
            end else if (k != 0) begin
                check("unexpected_strobe", k, 0);
            end
            if (k == 2) n_ferr++;
            if (k == 3) n_perr++;
            check("rx_data", bus.rx_data, exp_data);
        end
    end

    task automatic idle(input int n);
        @(negedge clk);
        line_rx = 1'b1;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_bad,
                              output int d0);
        logic [NBITS-1:0] bits;
        int kind;
        bits = '0;
        bits[0] = START_BIT;
        bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
        bits[9] = (^b) ^ par_bad;
`endif
        bits[NBITS-1] = stop;
        kind = !stop ? 2 : par_bad ? 3 : 1;
        @(negedge clk);
        line_rx = bits[0];
        d0 = cyc + 1;
        q.push_back('{cyc: d0 + LAT, kind: kind, data: b});
        repeat (CLK_DIV - 1) @(negedge clk);
        for (int i = 1; i < NBITS; i++) begin
            @(negedge clk);
            line_rx = bits[i];
            repeat (CLK_DIV - 1) @(negedge clk);
        end
    endtask

    task automatic glitch(input int len);
        @(negedge clk);
        line_rx = 1'b0;
        repeat (len - 1) @(negedge clk);
        idle(HALF + 6);
    endtask

    initial begin
        int d0, d1, v1, busy_cnt, ferr0;
        logic [7:0] b;
        logic stop, pbad;

        repeat (3) @(negedge clk);
        check("reset_rx_data", bus.rx_data, 8'h00);
        check("reset_rx_valid", bus.rx_valid, 0);
        check("reset_frame_err", bus.frame_err, 0);
        check("reset_busy", bus.busy, 0);
        rst_n = 1'b1;
        idle(10);

        // Single "G" frame with hand-computed latency
        send_frame(8'h47, 1'b1, 1'b0, d0);
        idle(20);
        check("lat_G", last_valid_cyc - d0, LAT_LIT);
        check("rx_data_G", bus.rx_data, 8'h47);

        // "G" then "1" with no idle gap
        send_frame(8'h47, 1'b1, 1'b0, d0);
        send_frame(8'h31, 1'b1, 1'b0, d1);
        v1 = d0 + LAT;
        idle(LAT);
        check("b2b_spacing", last_valid_cyc - v1, GAP_LIT);
        check("rx_data_1", bus.rx_data, 8'h31);

        // 4-cycle low glitch: busy for HALF cycles, no strobe
        busy_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            line_rx = (i < 4) ? 1'b0 : 1'b1;
        end
        check("glitch_busy_cycles", busy_cnt, 8);

        // Framing error with line held low, then recovery
        ferr0 = n_ferr;
        send_frame(8'h55, 1'b0, 1'b0, d0);
        hold(40);
        idle(10);
        check("ferr_count", n_ferr - ferr0, 1);
        check("rx_data_after_ferr", bus.rx_data, 8'h31);
        send_frame(8'hA5, 1'b1, 1'b0, d0);
        idle(20);
        check("rx_data_A5", bus.rx_data, 8'hA5);

        // Reset during bit 4 of 0xF3; bits 4..7 and stop are high, so no new edge follows
        @(negedge clk); line_rx = START_BIT; hold(CLK_DIV - 1);
        b = 8'hF3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); line_rx = b[i]; hold(CLK_DIV - 1);
        end
        @(negedge clk); line_rx = 1'b1; hold(4);
        check("busy_mid_frame", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_rx_data", bus.rx_data, 8'h00);
        check("midreset_rx_valid", bus.rx_valid, 0);
        check("midreset_frame_err", bus.frame_err, 0);
        check("midreset_busy", bus.busy, 0);
        hold(3);
        rst_n = 1'b1;
        idle(LAT + 10);
        check("busy_after_reset", bus.busy, 0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h47, 1'b1, 1'b0, d0);
        idle(20);
        check("par_good_data", bus.rx_data, 8'h47);
        v1 = n_perr;
        send_frame(8'h47, 1'b1, 1'b1, d0);
        idle(20);
        check("par_bad_count", n_perr - v1, 1);
`endif

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                glitch($urandom_range(1, HALF - 2));
            end else begin
                b = 8'($urandom);
                stop = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
                pbad = ($urandom_range(0, 3) == 0);
`else
                pbad = 1'b0;
`endif
                send_frame(b, stop, pbad, d0);
                if (!stop) begin
                    hold($urandom_range(0, 40));
                    idle($urandom_range(4, 20));
                end else begin
                    d1 = $urandom_range(0, 20);
                    if (d1 > 0) idle(d1);
                end
            end
        end

        idle(LAT + 20);
        check("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
